// File: rtl/channel_sample_reader.sv
// rtl/channel_sample_reader.sv - drains a burst of channel FIFO samples into a framed valid/ready stream
// Optional feature macro: CHANNEL_READER_CHECKSUM_EN (adds a checksum trailer word to normal frames)
module channel_sample_reader #(
   parameter int unsigned g_ChannelId     = 1,
   parameter int unsigned g_TimeoutCycles = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_Start,
   input  logic [7:0]  i_BurstLen,
   output logic        o_Busy,
   output logic        o_Done,
   output logic        o_Timeout,
   output logic        o_ReadSample,
   input  logic        i_ReadSampleEmpty,
   input  logic [15:0] i_ReadSampleData,
   output logic [15:0] o_TxData,
   output logic        o_TxValid,
   output logic        o_TxLast,
   input  logic        i_TxReady
);

   localparam logic [3:0]  c_ChannelTag  = 4'(g_ChannelId);
   // The counter value seen on the final tolerated empty cycle.
   localparam logic [15:0] c_TimeoutLast = 16'(g_TimeoutCycles - 1);
   localparam logic [15:0] c_TimeoutWord = 16'hDEAD;

   typedef enum logic [2:0] {
      StIdle,
      StHeader,
      StPop,
      StCapture,
      StSend,
      StTrailer,
      StDone
   } t_State;

   t_State      state;
   t_State      stateNext;

   logic [7:0]  lenField;      // header length field; 256 is carried as 8'h00
   logic [8:0]  remaining;     // samples still to be sent in this burst
   logic [15:0] sampleReg;     // sample currently offered on the stream
   logic [15:0] emptyCnt;      // consecutive empty cycles seen while waiting to pop

`ifdef CHANNEL_READER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   logic        loadBurst;
   logic        captureSample;
   logic        sampleAccept;
   logic        emptyTick;
   logic        timeoutHit;

   // State register; reset abandons any partial frame immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= StIdle;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decode plus all stream, FIFO and status outputs.
   always_comb begin
      stateNext     = state;
      o_Busy        = 1'b1;
      o_Done        = 1'b0;
      o_ReadSample  = 1'b0;
      o_TxData      = 16'h0000;
      o_TxValid     = 1'b0;
      o_TxLast      = 1'b0;
      loadBurst     = 1'b0;
      captureSample = 1'b0;
      sampleAccept  = 1'b0;
      emptyTick     = 1'b0;
      timeoutHit    = 1'b0;
      case (state)
         StIdle: begin
            o_Busy = 1'b0;
            if (i_Start) begin
               loadBurst = 1'b1;
               stateNext = StHeader;
            end
         end
         StHeader: begin
            o_TxData  = {4'hA, c_ChannelTag, lenField};
            o_TxValid = 1'b1;
            if (i_TxReady) begin
               stateNext = StPop;
            end
         end
         StPop: begin
            // The pop strobe is gated by reset so the FIFO is never touched while it is held.
            if (!i_ReadSampleEmpty && !reset) begin
               o_ReadSample = 1'b1;
               stateNext    = StCapture;
            end else if (emptyCnt == c_TimeoutLast) begin
               timeoutHit = 1'b1;
               stateNext  = StTrailer;
            end else begin
               emptyTick = 1'b1;
            end
         end
         StCapture: begin
            captureSample = 1'b1;
            stateNext     = StSend;
         end
         StSend: begin
            o_TxData  = sampleReg;
            o_TxValid = 1'b1;
`ifndef CHANNEL_READER_CHECKSUM_EN
            o_TxLast  = (remaining == 9'd1);
`endif
            if (i_TxReady) begin
               sampleAccept = 1'b1;
               if (remaining == 9'd1) begin
`ifdef CHANNEL_READER_CHECKSUM_EN
                  stateNext = StTrailer;
`else
                  stateNext = StDone;
`endif
               end else begin
                  stateNext = StPop;
               end
            end
         end
         StTrailer: begin
            o_TxValid = 1'b1;
            o_TxLast  = 1'b1;
`ifdef CHANNEL_READER_CHECKSUM_EN
            o_TxData  = o_Timeout ? c_TimeoutWord : checksum;
`else
            o_TxData  = c_TimeoutWord;
`endif
            if (i_TxReady) begin
               stateNext = StDone;
            end
         end
         StDone: begin
            o_Busy    = 1'b0;
            o_Done    = 1'b1;
            stateNext = StIdle;
         end
         default: begin
            stateNext = StIdle;
         end
      endcase
   end

   // Burst bookkeeping: length latch, remaining count and sample register.
   always_ff @(posedge clk) begin
      if (reset) begin
         lenField  <= 8'h00;
         remaining <= 9'd0;
         sampleReg <= 16'h0000;
      end else begin
         if (loadBurst) begin
            lenField  <= i_BurstLen;
            remaining <= (i_BurstLen == 8'h00) ? 9'd256 : {1'b0, i_BurstLen};
         end else if (sampleAccept) begin
            remaining <= remaining - 9'd1;
         end
         if (captureSample) begin
            sampleReg <= i_ReadSampleData;
         end
      end
   end

   // Empty-cycle watchdog and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         emptyCnt  <= 16'h0000;
         o_Timeout <= 1'b0;
      end else begin
         if (loadBurst || o_ReadSample || timeoutHit) begin
            emptyCnt <= 16'h0000;
         end else if (emptyTick) begin
            emptyCnt <= emptyCnt + 16'h0001;
         end
         if (loadBurst) begin
            o_Timeout <= 1'b0;
         end else if (timeoutHit) begin
            o_Timeout <= 1'b1;
         end
      end
   end

`ifdef CHANNEL_READER_CHECKSUM_EN
   // Running 16-bit sum of the samples captured in this burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum <= 16'h0000;
      end else if (loadBurst) begin
         checksum <= 16'h0000;
      end else if (captureSample) begin
         checksum <= checksum + i_ReadSampleData;
      end
   end
`endif

endmodule

// File: tb/tb_channel_sample_reader.sv
// tb/tb_channel_sample_reader.sv - scoreboard bench for channel_sample_reader
module tb_channel_sample_reader;

   localparam int c_Timeout = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  burstLen;
   logic        busy;
   logic        done;
   logic        timeoutFlag;
   logic        readSample;
   logic        fifoEmpty;
   logic [15:0] fifoData = 16'h0000;
   logic [15:0] txData;
   logic        txValid;
   logic        txLast;
   logic        txReady;
   logic        forceEmpty;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } t_Word;

   t_Word       expQ[$];
   logic [15:0] fifoQ[$];
   int          fifoCount = 0;

   int checks = 0;
   int errors = 0;

   int popCount   = 0;
   int doneCount  = 0;
   int framePops  = 0;
   int frameWords = 0;
   int idleRun    = 0;
   int lastGap    = 0;
   logic        prevStall = 1'b0;
   logic [15:0] prevData  = 16'h0000;
   logic        prevLast  = 1'b0;
   t_Word       monWord;

   assign fifoEmpty = forceEmpty || (fifoCount == 0);

   channel_sample_reader #(
      .g_ChannelId     (1),
      .g_TimeoutCycles (c_Timeout)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .i_Start           (start),
      .i_BurstLen        (burstLen),
      .o_Busy            (busy),
      .o_Done            (done),
      .o_Timeout         (timeoutFlag),
      .o_ReadSample      (readSample),
      .i_ReadSampleEmpty (fifoEmpty),
      .i_ReadSampleData  (fifoData),
      .o_TxData          (txData),
      .o_TxValid         (txValid),
      .o_TxLast          (txLast),
      .i_TxReady         (txReady)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   // FIFO model: pop strobe seen at the edge, data appears after it.
   always @(posedge clk) begin
      if (readSample && fifoQ.size() > 0) begin
         fifoData  <= fifoQ.pop_front();
         fifoCount <= fifoQ.size();
      end else begin
         fifoCount <= fifoQ.size();
      end
   end

   // Monitor: scoreboard compare, stream hold, and FIFO-side rules.
   always @(negedge clk) begin
      if (reset) begin
         prevStall = 1'b0;
      end else begin
         if (!busy) begin
            framePops  = 0;
            frameWords = 0;
         end
         if (prevStall) begin
            check("stream_hold", {15'd0, txValid, txLast, txData}, {15'd0, 1'b1, prevLast, prevData});
         end
         if (readSample) begin
            popCount++;
            framePops++;
            check("pop_while_empty", 32'(fifoEmpty), 32'd0);
            check("pop_ahead", 32'(framePops <= frameWords), 32'd1);
         end
         if (txValid && txReady) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: actual %h required none", {txLast, txData});
            end else begin
               monWord = expQ.pop_front();
               check("tx_word", {15'd0, txLast, txData}, {15'd0, monWord.last, monWord.data});
            end
            frameWords++;
            lastGap = idleRun;
            idleRun = 0;
         end else if (busy && !txValid) begin
            idleRun++;
         end
         if (done) begin
            doneCount++;
         end
         prevStall = txValid && !txReady;
         prevData  = txData;
         prevLast  = txLast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [15:0] data, input logic last);
      t_Word w;
      w.data = data;
      w.last = last;
      expQ.push_back(w);
   endtask

   // Expected sample words and trailer of a normal (non-timeout) frame.
   task automatic pushSamples(input logic [15:0] base, input logic [15:0] stride, input int n);
      logic [15:0] sum = 16'h0000;
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         v   = base + 16'(i) * stride;
         sum = sum + v;
`ifdef CHANNEL_READER_CHECKSUM_EN
         pushExp(v, 1'b0);
`else
         pushExp(v, i == n - 1);
`endif
      end
`ifdef CHANNEL_READER_CHECKSUM_EN
      pushExp(sum, 1'b1);
`endif
   endtask

   task automatic startBurst(input logic [7:0] len);
      burstLen = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      burstLen = 8'h5A;
   endtask

   task automatic waitDone(input string name, input int budget, input bit rnd);
      int base = doneCount;
      int n = 0;
      while (doneCount == base && n < budget) begin
         tick();
         if (rnd) txReady = 1'($urandom_range(0, 1));
         n++;
      end
      txReady = 1'b1;
      if (doneCount == base) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout: actual no o_Done after %0d cycles required one", name, budget);
      end
      tick();
      tick();
      check({name, "_done_once"}, 32'(doneCount - base), 32'd1);
      check({name, "_scoreboard_empty"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual simulation still running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int popBase;
      int n;
      reset      = 1'b1;
      start      = 1'b0;
      burstLen   = 8'h00;
      txReady    = 1'b1;
      forceEmpty = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {10'd0, busy, done, timeoutFlag, readSample, txValid, txLast, txData}, 32'd0);
      reset = 1'b0;
      tick();

      // T1: three samples with ready held high
      foreach (fifoQ[i]) fifoQ.delete(i);
      fifoQ.push_back(16'h0003);
      fifoQ.push_back(16'h0005);
      fifoQ.push_back(16'h0007);
      tick();
      pushExp(16'hA103, 1'b0);
      pushSamples(16'h0003, 16'h0002, 3);
      popBase = popCount;
      startBurst(8'd3);
      check("t1_busy", 32'(busy), 32'd1);
      waitDone("t1", 100, 1'b0);
      check("t1_pops", 32'(popCount - popBase), 32'd3);
      check("t1_timeout", 32'(timeoutFlag), 32'd0);

      // T2: length 0 means 256 samples
      for (int i = 0; i < 256; i++) fifoQ.push_back(16'(i));
      tick();
      pushExp(16'hA100, 1'b0);
      pushSamples(16'h0000, 16'h0001, 256);
      popBase = popCount;
      startBurst(8'd0);
      waitDone("t2", 1500, 1'b0);
      check("t2_pops", 32'(popCount - popBase), 32'd256);

      // T3: random backpressure
      for (int i = 1; i <= 4; i++) fifoQ.push_back(16'(i * 16'h1111));
      tick();
      pushExp(16'hA104, 1'b0);
      pushSamples(16'h1111, 16'h1111, 4);
      popBase = popCount;
      startBurst(8'd4);
      waitDone("t3", 300, 1'b1);
      check("t3_pops", 32'(popCount - popBase), 32'd4);

      // T4: FIFO runs dry after one of four samples
      fifoQ.push_back(16'h0001);
      tick();
      pushExp(16'hA104, 1'b0);
      pushExp(16'h0001, 1'b0);
      pushExp(16'hDEAD, 1'b1);
      popBase = popCount;
      startBurst(8'd4);
      waitDone("t4", 200, 1'b0);
      check("t4_timeout", 32'(timeoutFlag), 32'd1);
      check("t4_empty_cycles", 32'(lastGap), 32'(c_Timeout));
      check("t4_pops", 32'(popCount - popBase), 32'd1);

      // T5: reset while a sample is stalled in SEND
      fifoQ.push_back(16'h0011);
      fifoQ.push_back(16'h0022);
      tick();
      pushExp(16'hA102, 1'b0);
      pushExp(16'h0011, 1'b0);
      startBurst(8'd2);
      check("t5_timeout_cleared", 32'(timeoutFlag), 32'd0);
      n = 0;
      while (expQ.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      txReady = 1'b0;
      check("t5_first_words", 32'(expQ.size()), 32'd0);
      n = 0;
      while (!txValid && n < 20) begin
         tick();
         n++;
      end
      check("t5_stalled_word", {15'd0, txValid, txData}, {15'd0, 1'b1, 16'h0022});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_reset_outputs", {10'd0, busy, done, timeoutFlag, readSample, txValid, txLast, txData}, 32'd0);
      txReady = 1'b1;
      fifoQ.push_back(16'h0033);
      tick();
      pushExp(16'hA101, 1'b0);
      pushSamples(16'h0033, 16'h0000, 1);
      popBase = popCount;
      startBurst(8'd1);
      waitDone("t5", 100, 1'b0);
      check("t5_pops", 32'(popCount - popBase), 32'd1);

      // T6: start ignored while busy, one-cycle empty FIFO
      fifoQ.push_back(16'h0100);
      fifoQ.push_back(16'h0200);
      fifoQ.push_back(16'h0300);
      tick();
      pushExp(16'hA103, 1'b0);
      pushSamples(16'h0100, 16'h0100, 3);
      popBase = popCount;
      startBurst(8'd3);
      tick();
      tick();
      burstLen = 8'd5;
      start    = 1'b1;
      tick();
      start      = 1'b0;
      forceEmpty = 1'b1;
      tick();
      forceEmpty = 1'b0;
      waitDone("t6", 100, 1'b0);
      check("t6_pops", 32'(popCount - popBase), 32'd3);
      repeat (5) tick();
      check("t6_idle_after", {30'd0, busy, txValid}, 32'd0);
      check("final_scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
